tdes_sequencer: RTL and testbench
=================================

Name: tdes_sequencer

Overview:
- Downstream of AHBLiteSlaveController.
- Consumes enable, encryptionType, data and key1..key3, and runs three single-DES passes on an external DES engine through a start/done handshake (EDE for encrypt, DED for decrypt).
- Returns outputData and outputEnable to the slave for readback.

Parameters:
DATA_W, 64, block and key width
TIMEOUT_CYCLES, 64, watchdog limit in cycles per pass (used only with TDES_WATCHDOG_EN)

Ports:
HCLK  in  1  system clock, rising edge
HRESET  in  1  asynchronous active-low reset
enable  in  1  job request level from slave; a job starts on its rising edge
encryptionType  in  1  1 = encrypt (EDE), 0 = decrypt (DED)
data  in  DATA_W  input block
key1  in  DATA_W  key 1
key2  in  DATA_W  key 2
key3  in  DATA_W  key 3
outputData  out  DATA_W  final result, registered
outputEnable  out  1  result valid, level
busy  out  1  job in progress
des_start  out  1  one-cycle pulse to DES engine
des_decrypt  out  1  pass direction, held while pass active
des_key  out  DATA_W  pass key, held while pass active
des_in  out  DATA_W  pass input block, held while pass active
des_out  in  DATA_W  engine result, valid while des_done=1
des_done  in  1  one-cycle completion pulse from engine
timeout_err  out  1  sticky abort flag (TDES_WATCHDOG_EN only)

Behaviour:
- Reset (HRESET=0, async):
  - state IDLE; enable_q=0.
  - All outputs 0: outputData, outputEnable, busy, des_start, des_decrypt, des_key, des_in, timeout_err.
- Edge detect: go = enable & ~enable_q, where enable_q is registered every cycle.
  - go is honoured only in IDLE or DONE; ignored while busy (request lost).
  - Holding enable high does not retrigger.
- States: IDLE, START1, WAIT1, START2, WAIT2, START3, WAIT3, DONE.
- On go:
  - Latch data, keys and encryptionType into internal registers.
  - Clear outputEnable; set busy; next state START1.
  - Later changes on data or keys do not affect the running job.
- Pass table:
  - Encrypt: P1 key1 enc, P2 key2 dec, P3 key3 enc.
  - Decrypt: P1 key3 dec, P2 key2 enc, P3 key1 dec.
- STARTn:
  - Drive des_key and des_decrypt for pass n; des_in = latched data (P1) or previous des_out (P2, P3).
  - des_start=1 for exactly this cycle; next state WAITn.
- WAITn:
  - des_start=0; des_key, des_decrypt and des_in held stable.
  - On des_done=1, capture des_out into the intermediate register.
  - Go to START(n+1), or to DONE from WAIT3.
  - des_done outside WAIT states is ignored.
- DONE (entered the cycle after des_done in WAIT3):
  - outputData = P3 result; outputEnable=1; busy=0.
  - Stay until the next go, which starts a new job directly from DONE.
- Latency: with an engine returning des_done L cycles after des_start, outputEnable rises 3*(L+1)+1 cycles after the go edge. Example: L=1 gives 7 cycles.
- Reset mid-job: immediate return to IDLE with all outputs 0; an engine des_done arriving after reset is ignored.
- Simultaneous events:
  - go in DONE on the same cycle outputEnable would be held: the new job wins and outputEnable clears next cycle.
  - des_done and enable rising in the same WAIT cycle: des_done is processed, enable ignored.

Optional Feature:
- Macro: TDES_WATCHDOG_EN.
- Defined:
  - A per-pass counter clears in STARTn and increments in WAITn.
  - If it reaches TIMEOUT_CYCLES without des_done, go to IDLE: busy=0, outputEnable=0, timeout_err=1.
  - timeout_err stays set until the next accepted go or reset.
- Undefined:
  - No counter; the block waits indefinitely in WAITn.
  - timeout_err port is absent.

Decomposition:
- Package tdes_pkg:
  - DATA_W constant.
  - state_t enum (the 8 states).
  - pass_cfg_t struct {key_sel[1:0], decrypt}.
  - Constant arrays EDE_TABLE and DED_TABLE.
- Sub-module tdes_key_mux: combinational selection of key and direction from pass index and latched encryptionType.

Test Plan:
- Encrypt job: data=0x0000000000000001, key1/2/3=0x1111.../0x2222.../0x3333..., enable rising, XOR-stub engine (L=1) -> des_start pulses carry key1/enc, key2/dec, key3/enc in order; outputData=0x0000000000000001; outputEnable high 7 cycles after edge.
- Decrypt job, same inputs, encryptionType=0 -> key order key3/dec, key2/enc, key1/dec; busy=1 throughout; outputData=0x0000000000000001.
- Engine L=5, enable re-pulsed during WAIT2 and data changed mid-job -> second request ignored; result uses originally latched data; outputEnable at cycle 19.
- HRESET asserted during WAIT2 -> all outputs 0 asynchronously; a late des_done is ignored; next enable edge runs a clean job.
- Back-to-back jobs: go while in DONE -> outputEnable drops next cycle and the second result is correct; enable held high for 20 cycles produces exactly one job.
- (TDES_WATCHDOG_EN, TIMEOUT_CYCLES=8) engine never asserts des_done -> at the 8th WAIT1 cycle state returns to IDLE with timeout_err=1 and busy=0; the next go clears timeout_err.

Source files
------------

// File: rtl/tdes_pkg.sv
// Shared types, pass tables and helpers for the triple-DES sequencer.
package tdes_pkg;

   localparam int unsigned DATA_W = 64;

   typedef enum logic [2:0] {
      IDLE,
      START1,
      WAIT1,
      START2,
      WAIT2,
      START3,
      WAIT3,
      DONE
   } state_t;

   typedef struct packed {
      logic [1:0] key_sel;
      logic       decrypt;
   } pass_cfg_t;

   localparam logic [1:0] KEY1 = 2'd0;
   localparam logic [1:0] KEY2 = 2'd1;
   localparam logic [1:0] KEY3 = 2'd2;

   // Index 0 is the first pass of the job.
   localparam pass_cfg_t [2:0] EDE_TABLE = '{
      pass_cfg_t'{KEY3, 1'b0},
      pass_cfg_t'{KEY2, 1'b1},
      pass_cfg_t'{KEY1, 1'b0}
   };

   localparam pass_cfg_t [2:0] DED_TABLE = '{
      pass_cfg_t'{KEY1, 1'b1},
      pass_cfg_t'{KEY2, 1'b0},
      pass_cfg_t'{KEY3, 1'b1}
   };

   // Key/direction for a pass; out-of-range index falls back to key1/encrypt.
   function automatic pass_cfg_t pass_lookup(input logic encrypt, input logic [1:0] idx);
      pass_cfg_t cfg;
      cfg = pass_cfg_t'{KEY1, 1'b0};
      case (idx)
         2'd0:    cfg = encrypt ? EDE_TABLE[0] : DED_TABLE[0];
         2'd1:    cfg = encrypt ? EDE_TABLE[1] : DED_TABLE[1];
         2'd2:    cfg = encrypt ? EDE_TABLE[2] : DED_TABLE[2];
         default: cfg = pass_cfg_t'{KEY1, 1'b0};
      endcase
      return cfg;
   endfunction

   // Pass index associated with a START/WAIT state.
   function automatic logic [1:0] state_pass(input state_t s);
      logic [1:0] idx;
      case (s)
         START1, WAIT1: idx = 2'd0;
         START2, WAIT2: idx = 2'd1;
         default:       idx = 2'd2;
      endcase
      return idx;
   endfunction

   function automatic logic is_start(input state_t s);
      return (s == START1) || (s == START2) || (s == START3);
   endfunction

endpackage

// File: rtl/tdes_key_mux.sv
// Selects the key and direction for one DES pass from the pass index and job type.
module tdes_key_mux
   import tdes_pkg::*;
(
   input  logic [1:0]        pass_idx,
   input  logic              encrypt,
   input  logic [DATA_W-1:0] key1,
   input  logic [DATA_W-1:0] key2,
   input  logic [DATA_W-1:0] key3,
   output logic [DATA_W-1:0] key_c,
   output logic              decrypt_c
);

   pass_cfg_t cfg_c;

   // Table lookup followed by the key select.
   always_comb begin
      cfg_c     = pass_lookup(encrypt, pass_idx);
      decrypt_c = cfg_c.decrypt;
      case (cfg_c.key_sel)
         KEY2:    key_c = key2;
         KEY3:    key_c = key3;
         default: key_c = key1;
      endcase
   end

endmodule

// File: rtl/tdes_sequencer.sv
// Triple-DES sequencer: runs EDE (encrypt) or DED (decrypt) as three passes on an
// external single-DES engine via a start/done handshake.
// Optional per-pass watchdog enabled by defining TDES_WATCHDOG_EN.
module tdes_sequencer
   import tdes_pkg::*;
`ifdef TDES_WATCHDOG_EN
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
)
`endif
(
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              enable,
   input  logic              encryptionType,
   input  logic [DATA_W-1:0] data,
   input  logic [DATA_W-1:0] key1,
   input  logic [DATA_W-1:0] key2,
   input  logic [DATA_W-1:0] key3,
   output logic [DATA_W-1:0] outputData,
   output logic              outputEnable,
   output logic              busy,
   output logic              des_start,
   output logic              des_decrypt,
   output logic [DATA_W-1:0] des_key,
   output logic [DATA_W-1:0] des_in,
   input  logic [DATA_W-1:0] des_out,
   input  logic              des_done
`ifdef TDES_WATCHDOG_EN
   ,
   output logic              timeout_err
`endif
);

   state_t            state_q, state_d;
   logic              enable_q, enable_d;
   logic              go_c;
   logic              enc_q, enc_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] key1_q, key1_d;
   logic [DATA_W-1:0] key2_q, key2_d;
   logic [DATA_W-1:0] key3_q, key3_d;
   logic [DATA_W-1:0] mid_q, mid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_en_q, out_en_d;
   logic              busy_q, busy_d;
   logic              des_start_q, des_start_d;
   logic              des_dec_q, des_dec_d;
   logic [DATA_W-1:0] des_key_q, des_key_d;
   logic [DATA_W-1:0] des_in_q, des_in_d;
   logic [1:0]        pass_idx_c;
   logic [DATA_W-1:0] pass_key_c;
   logic              pass_dec_c;

`ifdef TDES_WATCHDOG_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             terr_q, terr_d;
`endif

   // Pass outputs are registered, so they are derived from the state being entered.
   assign pass_idx_c = state_pass(state_d);

   tdes_key_mux u_key_mux (
      .pass_idx  (pass_idx_c),
      .encrypt   (enc_d),
      .key1      (key1_d),
      .key2      (key2_d),
      .key3      (key3_d),
      .key_c     (pass_key_c),
      .decrypt_c (pass_dec_c)
   );

   // Next-state, job latching and result capture.
   always_comb begin
      state_d    = state_q;
      enable_d   = enable;
      enc_d      = enc_q;
      data_d     = data_q;
      key1_d     = key1_q;
      key2_d     = key2_q;
      key3_d     = key3_q;
      mid_d      = mid_q;
      out_data_d = out_data_q;
      out_en_d   = out_en_q;
      busy_d     = busy_q;
`ifdef TDES_WATCHDOG_EN
      cnt_d      = cnt_q;
      terr_d     = terr_q;
`endif
      go_c       = enable & ~enable_q;

      case (state_q)
         IDLE, DONE: begin
            if (go_c) begin
               enc_d    = encryptionType;
               data_d   = data;
               key1_d   = key1;
               key2_d   = key2;
               key3_d   = key3;
               out_en_d = 1'b0;
               busy_d   = 1'b1;
               state_d  = START1;
`ifdef TDES_WATCHDOG_EN
               terr_d   = 1'b0;
`endif
            end
         end
         START1: state_d = WAIT1;
         START2: state_d = WAIT2;
         START3: state_d = WAIT3;
         WAIT1, WAIT2, WAIT3: begin
            if (des_done) begin
               mid_d = des_out;
               if (state_q == WAIT1) begin
                  state_d = START2;
               end else if (state_q == WAIT2) begin
                  state_d = START3;
               end else begin
                  state_d    = DONE;
                  out_data_d = des_out;
                  out_en_d   = 1'b1;
                  busy_d     = 1'b0;
               end
            end
`ifdef TDES_WATCHDOG_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d  = IDLE;
               busy_d   = 1'b0;
               out_en_d = 1'b0;
               terr_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         default: state_d = IDLE;
      endcase

`ifdef TDES_WATCHDOG_EN
      if (is_start(state_q)) begin
         cnt_d = '0;
      end
`endif
   end

   // Engine-side drive: start pulse plus key/direction/input held for the whole pass.
   always_comb begin
      des_start_d = 1'b0;
      des_dec_d   = des_dec_q;
      des_key_d   = des_key_q;
      des_in_d    = des_in_q;
      if (is_start(state_d)) begin
         des_start_d = 1'b1;
         des_dec_d   = pass_dec_c;
         des_key_d   = pass_key_c;
         des_in_d    = (state_d == START1) ? data_d : mid_d;
      end
   end

   // State and output registers.
   always_ff @(posedge HCLK or negedge HRESET) begin
      if (!HRESET) begin
         state_q     <= IDLE;
         enable_q    <= 1'b0;
         enc_q       <= 1'b0;
         data_q      <= '0;
         key1_q      <= '0;
         key2_q      <= '0;
         key3_q      <= '0;
         mid_q       <= '0;
         out_data_q  <= '0;
         out_en_q    <= 1'b0;
         busy_q      <= 1'b0;
         des_start_q <= 1'b0;
         des_dec_q   <= 1'b0;
         des_key_q   <= '0;
         des_in_q    <= '0;
`ifdef TDES_WATCHDOG_EN
         cnt_q       <= '0;
         terr_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         enable_q    <= enable_d;
         enc_q       <= enc_d;
         data_q      <= data_d;
         key1_q      <= key1_d;
         key2_q      <= key2_d;
         key3_q      <= key3_d;
         mid_q       <= mid_d;
         out_data_q  <= out_data_d;
         out_en_q    <= out_en_d;
         busy_q      <= busy_d;
         des_start_q <= des_start_d;
         des_dec_q   <= des_dec_d;
         des_key_q   <= des_key_d;
         des_in_q    <= des_in_d;
`ifdef TDES_WATCHDOG_EN
         cnt_q       <= cnt_d;
         terr_q      <= terr_d;
`endif
      end
   end

   assign outputData   = out_data_q;
   assign outputEnable = out_en_q;
   assign busy         = busy_q;
   assign des_start    = des_start_q;
   assign des_decrypt  = des_dec_q;
   assign des_key      = des_key_q;
   assign des_in       = des_in_q;
`ifdef TDES_WATCHDOG_EN
   assign timeout_err  = terr_q;
`endif

endmodule

// File: tb/tb_tdes_sequencer.sv
// Self-checking bench for tdes_sequencer with a behavioural DES engine stub.
// Watchdog checks are built when TDES_WATCHDOG_EN is defined.
module tb_tdes_sequencer;
   import tdes_pkg::*;

   logic              HCLK = 1'b0;
   logic              HRESET;
   logic              enable;
   logic              encryptionType;
   logic [DATA_W-1:0] data, key1, key2, key3;
   logic [DATA_W-1:0] outputData;
   logic              outputEnable, busy, des_start, des_decrypt;
   logic [DATA_W-1:0] des_key, des_in;
   logic [DATA_W-1:0] des_out;
   logic              des_done;
`ifdef TDES_WATCHDOG_EN
   logic              timeout_err;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [63:0] key;
      logic        dec;
      logic [63:0] din;
   } pass_rec_t;

   pass_rec_t log_q[$];

   int          eng_mode = 0;
   int          eng_lat  = 1;
   bit          eng_mute = 1'b0;
   int          eng_cnt  = 0;
   logic [63:0] p_in, p_key;
   logic        p_dec;

   always #5 HCLK = ~HCLK;

`ifdef TDES_WATCHDOG_EN
   tdes_sequencer #(.TIMEOUT_CYCLES(8)) dut (
      .HCLK           (HCLK),
      .HRESET         (HRESET),
      .enable         (enable),
      .encryptionType (encryptionType),
      .data           (data),
      .key1           (key1),
      .key2           (key2),
      .key3           (key3),
      .outputData     (outputData),
      .outputEnable   (outputEnable),
      .busy           (busy),
      .des_start      (des_start),
      .des_decrypt    (des_decrypt),
      .des_key        (des_key),
      .des_in         (des_in),
      .des_out        (des_out),
      .des_done       (des_done),
      .timeout_err    (timeout_err)
   );
`else
   tdes_sequencer dut (
      .HCLK           (HCLK),
      .HRESET         (HRESET),
      .enable         (enable),
      .encryptionType (encryptionType),
      .data           (data),
      .key1           (key1),
      .key2           (key2),
      .key3           (key3),
      .outputData     (outputData),
      .outputEnable   (outputEnable),
      .busy           (busy),
      .des_start      (des_start),
      .des_decrypt    (des_decrypt),
      .des_key        (des_key),
      .des_in         (des_in),
      .des_out        (des_out),
      .des_done       (des_done)
   );
`endif

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Single-DES stand-in: mode 0 is a plain XOR, mode 1 a direction-dependent invertible mix.
   function automatic logic [63:0] eng_f(input int mode, input logic [63:0] x,
                                         input logic [63:0] k, input logic dec);
      logic [63:0] t;
      if (mode == 0) return x ^ k;
      if (!dec) begin
         t = {x[62:0], x[63]};
         return t ^ k;
      end
      t = x ^ k;
      return {t[0], t[63:1]};
   endfunction

   // Engine: observes start at negedge, answers with a one-cycle done eng_lat cycles later.
   always @(negedge HCLK) begin
      des_done = 1'b0;
      des_out  = {$urandom(), $urandom()};
      if (eng_cnt > 1) begin
         eng_cnt--;
      end else if (eng_cnt == 1) begin
         eng_cnt = 0;
         if (!eng_mute) begin
            if (busy === 1'b1) begin
               chk("des_in_held", des_in, p_in);
               chk("des_key_held", des_key, p_key);
               chk("des_dec_held", 64'(des_decrypt), 64'(p_dec));
            end
            des_done = 1'b1;
            des_out  = eng_f(eng_mode, p_in, p_key, p_dec);
         end
      end
      if (des_start === 1'b1) begin
         log_q.push_back(pass_rec_t'{des_key, des_decrypt, des_in});
         p_in    = des_in;
         p_key   = des_key;
         p_dec   = des_decrypt;
         eng_cnt = eng_lat;
      end
   end

   // One complete job from an enable edge; optionally re-pulses enable and alters inputs mid-job.
   task automatic run_job(input logic enc, input logic [63:0] d, input logic [63:0] k1,
                          input logic [63:0] k2, input logic [63:0] k3, input int lat,
                          input bit tamper);
      logic [63:0] ek[3];
      logic        ed[3];
      logic [63:0] ei[3];
      logic [63:0] v;
      int          n;
      bit          done_seen, busy_ok;
      if (enc) begin
         ek[0] = k1; ek[1] = k2; ek[2] = k3;
         ed[0] = 1'b0; ed[1] = 1'b1; ed[2] = 1'b0;
      end else begin
         ek[0] = k3; ek[1] = k2; ek[2] = k1;
         ed[0] = 1'b1; ed[1] = 1'b0; ed[2] = 1'b1;
      end
      v = d;
      for (int i = 0; i < 3; i++) begin
         ei[i] = v;
         v = eng_f(eng_mode, v, ek[i], ed[i]);
      end

      @(negedge HCLK);
      enable = 1'b0;
      @(negedge HCLK);
      eng_lat = lat;
      log_q.delete();
      encryptionType = enc;
      data = d; key1 = k1; key2 = k2; key3 = k3;
      enable = 1'b1;
      n = 0; done_seen = 1'b0; busy_ok = 1'b1;
      while (n < 300 && !done_seen) begin
         @(negedge HCLK);
         n++;
         if (n == 1) begin
            chk("oe_clear_on_go", 64'(outputEnable), 64'd0);
            chk("busy_on_go", 64'(busy), 64'd1);
`ifdef TDES_WATCHDOG_EN
            chk("terr_clear_on_go", 64'(timeout_err), 64'd0);
`endif
         end
         if (tamper && n == lat + 3) begin
            enable = 1'b0;
            data = ~d;
            key1 = ~k1;
            key3 = ~k3;
         end
         if (tamper && n == lat + 4) enable = 1'b1;
         if (outputEnable === 1'b1) done_seen = 1'b1;
         else if (busy !== 1'b1) busy_ok = 1'b0;
      end
      chk("latency", 64'(n), 64'(3 * (lat + 1) + 1));
      chk("busy_during_job", 64'(busy_ok), 64'd1);
      chk("output_data", outputData, v);
      chk("busy_at_done", 64'(busy), 64'd0);
      chk("pass_count", 64'(log_q.size()), 64'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < log_q.size()) begin
            chk($sformatf("p%0d_key", i + 1), log_q[i].key, ek[i]);
            chk($sformatf("p%0d_dec", i + 1), 64'(log_q[i].dec), 64'(ed[i]));
            chk($sformatf("p%0d_in", i + 1), log_q[i].din, ei[i]);
         end
      end
   endtask

   initial begin
      int          snap;
      bit          quiet;
      logic [63:0] r1, r2, r3, r4;

      HRESET = 1'b1;
      enable = 1'b0;
      encryptionType = 1'b0;
      data = '0; key1 = '0; key2 = '0; key3 = '0;
      des_out = '0; des_done = 1'b0;
      #2 HRESET = 1'b0;
      repeat (3) @(negedge HCLK);
      chk("rst_outputData", outputData, 64'd0);
      chk("rst_outputEnable", 64'(outputEnable), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_des_start", 64'(des_start), 64'd0);
      chk("rst_des_decrypt", 64'(des_decrypt), 64'd0);
      chk("rst_des_key", des_key, 64'd0);
      chk("rst_des_in", des_in, 64'd0);
`ifdef TDES_WATCHDOG_EN
      chk("rst_timeout_err", 64'(timeout_err), 64'd0);
`endif
      HRESET = 1'b1;

      // Directed encrypt and decrypt with the XOR stub, L=1.
      eng_mode = 0;
      run_job(1'b1, 64'h1, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
              64'h3333_3333_3333_3333, 1, 1'b0);
      chk("enc_directed_result", outputData, 64'h1);
      run_job(1'b0, 64'h1, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
              64'h3333_3333_3333_3333, 1, 1'b0);
      chk("dec_directed_result", outputData, 64'h1);

      // L=5 with a lost mid-job request and altered inputs.
      eng_mode = 1;
      r1 = {$urandom(), $urandom()}; r2 = {$urandom(), $urandom()};
      r3 = {$urandom(), $urandom()}; r4 = {$urandom(), $urandom()};
      run_job(1'b1, r1, r2, r3, r4, 5, 1'b1);

      // Enable held high in DONE must not retrigger.
      snap = log_q.size();
      repeat (20) @(negedge HCLK);
      chk("hold_no_retrigger", 64'(log_q.size()), 64'(snap));
      chk("hold_oe_kept", 64'(outputEnable), 64'd1);

      // Asynchronous reset during WAIT2; a late done must be ignored.
      @(negedge HCLK);
      enable = 1'b0;
      @(negedge HCLK);
      eng_lat = 5;
      data = {$urandom(), $urandom()};
      encryptionType = 1'b0;
      enable = 1'b1;
      repeat (9) @(negedge HCLK);
      chk("pre_rst_busy", 64'(busy), 64'd1);
      #2 HRESET = 1'b0;
      #1;
      chk("mid_rst_outputData", outputData, 64'd0);
      chk("mid_rst_outputEnable", 64'(outputEnable), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_des_key", des_key, 64'd0);
      chk("mid_rst_des_in", des_in, 64'd0);
      chk("mid_rst_des_decrypt", 64'(des_decrypt), 64'd0);
      enable = 1'b0;
      @(negedge HCLK);
      HRESET = 1'b1;
      snap = log_q.size();
      quiet = 1'b1;
      repeat (8) begin
         @(negedge HCLK);
         if (busy !== 1'b0 || outputEnable !== 1'b0 || des_start !== 1'b0) quiet = 1'b0;
      end
      chk("late_done_ignored", 64'(quiet), 64'd1);
      chk("no_start_after_rst", 64'(log_q.size()), 64'(snap));
      run_job(1'b1, 64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210,
              64'h0f0f_0f0f_f0f0_f0f0, 64'haaaa_5555_aaaa_5555, 2, 1'b0);

      // Back-to-back random jobs, each started from DONE.
      for (int j = 0; j < 6; j++) begin
         r1 = {$urandom(), $urandom()}; r2 = {$urandom(), $urandom()};
         r3 = {$urandom(), $urandom()}; r4 = {$urandom(), $urandom()};
         run_job(1'($urandom_range(0, 1)), r1, r2, r3, r4, $urandom_range(1, 4), 1'b0);
      end

`ifdef TDES_WATCHDOG_EN
      // Engine never answers: abort after 8 WAIT1 cycles.
      eng_mute = 1'b1;
      @(negedge HCLK);
      enable = 1'b0;
      @(negedge HCLK);
      eng_lat = 1;
      enable = 1'b1;
      repeat (9) @(negedge HCLK);
      chk("wd_busy_before", 64'(busy), 64'd1);
      chk("wd_terr_before", 64'(timeout_err), 64'd0);
      @(negedge HCLK);
      chk("wd_busy_after", 64'(busy), 64'd0);
      chk("wd_terr_after", 64'(timeout_err), 64'd1);
      chk("wd_oe_after", 64'(outputEnable), 64'd0);
      repeat (5) @(negedge HCLK);
      chk("wd_terr_sticky", 64'(timeout_err), 64'd1);
      eng_mute = 1'b0;
      run_job(1'b0, 64'h5, 64'h6, 64'h7, 64'h8, 1, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
